// File: rtl/dm_ahb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : dm_ahb_pkg
// Purpose  : AHB-Lite encodings and the stream writer state type.
// Revision : 1.0
// =============================================================================
package dm_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HBURST_INCR = 3'b001;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_LAST = 2'd2,
        ST_ERR  = 2'd3
    } writer_state_t;

endpackage
`default_nettype wire

// File: rtl/dm_sync_fifo.sv
`default_nettype none
// =============================================================================
// Module   : dm_sync_fifo
// Purpose  : Synchronous FIFO, power-of-2 depth, flush, push-while-full-on-pop.
// Revision : 1.0
// =============================================================================
module dm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dm_ahb_stream_writer.sv
`default_nettype none
// =============================================================================
// Module   : dm_ahb_stream_writer
// Purpose  : Stream-to-AHB-Lite INCR word burst writer. Optional wait-cycle
//            counter enabled by macro DM_AHB_STREAM_WRITER_PERF_EN.
// Revision : 1.0
// =============================================================================
module dm_ahb_stream_writer
    import dm_ahb_pkg::*;
#(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic [AHB_AWIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
`ifdef DM_AHB_STREAM_WRITER_PERF_EN
    output logic [15:0]           wait_cycles,
`endif
    input  logic                  in_valid,
    input  logic [AHB_DWIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [AHB_AWIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [AHB_DWIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    writer_state_t         state, state_nxt;
    logic [AHB_AWIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [AHB_DWIDTH-1:0] wdata;
    logic                  need_nonseq;
    logic                  ready_en;
    logic                  done_r;
    logic                  error_r;
    logic                  fifo_full, fifo_empty, fifo_pop, fifo_flush, fifo_push;
    logic [AHB_DWIDTH-1:0] fifo_dout;
    logic                  start_ok, beat_ok, last_ok, err_first;
    logic [1:0]            htrans;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^base_addr[1:0];

    // First cycle of a two-cycle ERROR response; must cancel the pending beat now.
    assign err_first = !HREADY && (HRESP == HRESP_ERROR);

    assign in_ready  = ready_en && !fifo_full && (state != ST_ERR);
    assign fifo_push = in_valid && in_ready;

    dm_sync_fifo #(
        .WIDTH (AHB_DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        htrans     = HTRANS_IDLE;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        start_ok   = 1'b0;
        beat_ok    = 1'b0;
        last_ok    = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (word_count == '0) ? ST_IDLE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (err_first) begin
                    fifo_flush = 1'b1;
                    state_nxt  = ST_ERR;
                end else if (!fifo_empty && (remaining != '0)) begin
                    htrans = (need_nonseq || (addr[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (HREADY) begin
                        beat_ok  = 1'b1;
                        fifo_pop = 1'b1;
                        if (remaining == CNT_WIDTH'(1)) state_nxt = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                if (err_first) begin
                    fifo_flush = 1'b1;
                    state_nxt  = ST_ERR;
                end else if (HREADY && (HRESP == HRESP_OKAY)) begin
                    last_ok   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr        <= '0;
            remaining   <= '0;
            wdata       <= '0;
            need_nonseq <= 1'b1;
            ready_en    <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done_r   <= last_ok || (start_ok && (word_count == '0));
            if (start_ok) begin
                addr        <= {base_addr[AHB_AWIDTH-1:2], 2'b00};
                remaining   <= word_count;
                need_nonseq <= 1'b1;
                error_r     <= 1'b0;
            end else if (beat_ok) begin
                addr        <= addr + AHB_AWIDTH'(4);
                remaining   <= remaining - CNT_WIDTH'(1);
                wdata       <= fifo_dout;
                need_nonseq <= 1'b0;
            end else if ((state == ST_XFER) && (htrans == HTRANS_IDLE)) begin
                // An idle gap breaks the burst; the next beat restarts with NONSEQ.
                need_nonseq <= 1'b1;
            end
            if (fifo_flush) error_r <= 1'b1;
        end
    end

`ifdef DM_AHB_STREAM_WRITER_PERF_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (start_ok) begin
            wait_cnt <= '0;
        end else if (busy && (!HREADY || fifo_empty) && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign wait_cycles = wait_cnt;
`endif

    assign busy   = (state == ST_XFER) || (state == ST_LAST);
    assign done   = done_r;
    assign error  = error_r;
    assign HADDR  = addr;
    assign HTRANS = htrans;
    assign HWDATA = wdata;
    assign HWRITE = 1'b1;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_INCR;

endmodule
`default_nettype wire
